// File: rtl/aes_inv_pkg.sv
// Shared definitions for the AES inverse first round: FSM encoding,
// geometry constants and byte/column index helpers for the 128-bit state.
package aes_inv_pkg;

    // Control states: wait for input, substitute one column per cycle, present result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int N_COLS = 4;
    localparam int N_ROWS = 4;

    // Byte index within the state: byte 4c+r holds row r of column c.
    function automatic logic [3:0] byte_idx(input logic [1:0] r, input logic [1:0] c);
        return {c, r};
    endfunction

    // Bit position of the least significant bit of byte idx (byte 0 sits at [127:120]).
    function automatic logic [6:0] byte_lsb(input logic [3:0] idx);
        return {~idx, 3'b000};
    endfunction

    // InvShiftRows: output byte (r,c) is taken from input column (c - r) mod 4.
    function automatic logic [1:0] inv_sr_src_col(input logic [1:0] r, input logic [1:0] c);
        return c - r;
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational 8-bit AES inverse S-box lookup (FIPS-197 table).
module inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign y = INV_SBOX[a];

endmodule

// File: rtl/inv_first_round.sv
// AES inverse first round: data_out = InvSubBytes(InvShiftRows(data_in ^ key_in)).
// AddRoundKey and InvShiftRows happen on the accepting edge; the inverse
// S-box is then applied one column per cycle through four lookups.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE (and never during reset); out_valid is 1
// only in DONE, where data_out and out_valid stay frozen until out_ready.
module inv_first_round
    import aes_inv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);

    state_e       state_q, state_d;
    logic [1:0]   col_cnt_q, col_cnt_d;
    logic [127:0] st_q, st_d;

    logic [127:0] ark;
    logic [127:0] isr;
    logic [7:0]   col_in  [N_ROWS];
    logic [7:0]   col_out [N_ROWS];

    // AddRoundKey followed by InvShiftRows on the incoming block.
    always_comb begin
        ark = data_in ^ key_in;
        isr = '0;
        for (int c = 0; c < N_COLS; c++) begin
            for (int r = 0; r < N_ROWS; r++) begin
                isr[byte_lsb(byte_idx(2'(r), 2'(c))) +: 8] =
                    ark[byte_lsb(byte_idx(2'(r), inv_sr_src_col(2'(r), 2'(c)))) +: 8];
            end
        end
    end

    // Pick out the four bytes of the column currently being substituted.
    always_comb begin
        for (int r = 0; r < N_ROWS; r++) begin
            col_in[r] = st_q[byte_lsb(byte_idx(2'(r), col_cnt_q)) +: 8];
        end
    end

    // One inverse S-box per row of the active column.
    for (genvar g = 0; g < N_ROWS; g++) begin : g_row_sbox
        inv_sbox u_inv_sbox (
            .a (col_in[g]),
            .y (col_out[g])
        );
    end

    // Next-state logic: accept, substitute columns 0..3, then hold until taken.
    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        st_d      = st_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    st_d      = isr;
                    col_cnt_d = 2'd0;
                    state_d   = SUB;
                end
            end
            SUB: begin
                for (int r = 0; r < N_ROWS; r++) begin
                    st_d[byte_lsb(byte_idx(2'(r), col_cnt_q)) +: 8] = col_out[r];
                end
                col_cnt_d = col_cnt_q + 2'd1;
                if (col_cnt_q == 2'(N_COLS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, column counter and datapath registers; reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            col_cnt_q <= 2'd0;
            st_q      <= '0;
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            st_q      <= st_d;
        end
    end

    // in_ready is gated by rst_n so nothing is offered while reset is held.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign data_out  = st_q;

endmodule

// File: tb/tb_inv_first_round.sv
// Bench for inv_first_round. The reference builds the AES S-box from
// GF(2^8) arithmetic, inverts it, and applies the round byte by byte.
module tb_inv_first_round;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;

    logic [127:0] exp_q[$];
    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];

    localparam logic [127:0] C1_DATA = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_KEY  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    // 7ad5fda7... is only data^key (the C.1 "istart" row); the full inverse
    // round (InvShiftRows then InvSubBytes) is the C.1 "is_box" value below.
    localparam logic [127:0] C1_OUT  = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
    localparam logic [127:0] ALL_52  = {16{8'h52}};
    localparam logic [127:0] ALL_63  = {16{8'h63}};

    // clock / reset
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    inv_first_round dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .key_in    (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // reference model
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [7:0] t = b;
        for (int i = 0; i < n; i++) t = {t[6:0], t[7]};
        return t;
    endfunction

    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] bx  = 8'(x);
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(bx, 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
    endtask

    function automatic logic [7:0] gbyte(input logic [127:0] v, input int i);
        return v[127 - 8*i -: 8];
    endfunction

    // Expected inverse round: byte (r,c) = InvS(t[r][(c-r) mod 4]), t = d ^ k.
    function automatic logic [127:0] model_round(input logic [127:0] d, input logic [127:0] k);
        logic [127:0] t = d ^ k;
        logic [127:0] o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = isb[gbyte(t, 4*((c - r + 4) % 4) + r)];
        return o;
    endfunction

    // Encryption last round: ShiftRows(SubBytes(x)) ^ k.
    function automatic logic [127:0] fwd_round(input logic [127:0] x, input logic [127:0] k);
        logic [127:0] o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = sb[gbyte(x, 4*((c + r) % 4) + r)];
        return o ^ k;
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [127:0] d, input logic [127:0] k);
        int waitc = 0;
        while (!in_ready && waitc < 30) begin
            tick();
            waitc++;
        end
        if (!in_ready) begin
            check("send_ready", 128'(in_ready), 128'd1);
            return;
        end
        in_valid = 1'b1;
        data_in  = d;
        key_in   = k;
        tick();
        in_valid = 1'b0;
        acc_cyc  = cyc;
        exp_q.push_back(model_round(d, k));
    endtask

    task automatic drain();
        int waitc = 0;
        while (exp_q.size() != 0 && waitc < 40) begin
            tick();
            waitc++;
        end
        check("drain", 128'(exp_q.size()), 128'd0);
    endtask

    // scoreboard: compare every presented result against the expected queue
    logic         prev_hold = 1'b0;
    logic         prev_hs   = 1'b0;
    logic [127:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold <= 1'b0;
            prev_hs   <= 1'b0;
        end else begin
            if (prev_hs) begin
                check("ready_after_hs", 128'(in_ready), 128'd1);
                check("valid_after_hs", 128'(out_valid), 128'd0);
            end
            if (out_valid) begin
                check("ready_in_done", 128'(in_ready), 128'd0);
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 128'(out_valid), 128'd0);
                end else begin
                    check("data_out", data_out, exp_q[0]);
                    if (!prev_hold) check("latency", 128'(cyc - acc_cyc), 128'd4);
                    else            check("hold_stable", data_out, prev_data);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            prev_hs   <= out_valid && out_ready;
            prev_hold <= out_valid && !out_ready;
            prev_data <= data_out;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: sim time %0t exceeded budget", $time);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    // stimulus
    initial begin
        logic [127:0] x, k, y, hold;
        int a0, w;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data_in   = '0;
        key_in    = '0;

        build_tables();
        check("pin_sb_00", 128'(sb[8'h00]), 128'h63);
        check("pin_sb_53", 128'(sb[8'h53]), 128'hed);
        check("pin_isb_00", 128'(isb[8'h00]), 128'h52);
        check("pin_isb_7a", 128'(isb[8'h7a]), 128'hbd);
        check("pin_model_c1", model_round(C1_DATA, C1_KEY), C1_OUT);
        check("pin_model_zero", model_round('0, '0), ALL_52);
        check("pin_model_ident", model_round(ALL_63, '0), 128'd0);
        check("pin_fwd_c1", fwd_round(C1_OUT, C1_KEY), C1_DATA);

        // reset state
        tick(); tick(); tick();
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd0);
        check("rst_data_out", data_out, 128'd0);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", 128'(in_ready), 128'd1);
        tick();

        // directed vectors with out_ready held high
        send(C1_DATA, C1_KEY);
        drain();
        send('0, '0);
        drain();
        send(ALL_63, '0);
        drain();
        send(128'h00112233445566778899aabbccddeeff, 128'h0f0e0d0c0b0a09080706050403020100);
        drain();

        // back-to-back inputs: one result per 6 cycles
        send(128'h0123456789abcdeffedcba9876543210, 128'hffffffff00000000ffffffff00000000);
        a0 = acc_cyc;
        send(128'hdeadbeefcafef00d0badc0de12345678, 128'h0);
        check("throughput", 128'(acc_cyc - a0), 128'd6);
        drain();

        // backpressure: hold DONE for 10 cycles, with in_valid ignored meanwhile
        out_ready = 1'b0;
        send(C1_DATA, C1_KEY);
        in_valid = 1'b1;
        data_in  = '0;
        key_in   = '0;
        w = 0;
        while (!out_valid && w < 20) begin
            tick();
            w++;
        end
        check("bp_valid_rises", 128'(out_valid), 128'd1);
        hold = data_out;
        check("bp_data", hold, C1_OUT);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 128'(out_valid), 128'd1);
            check("bp_ready", 128'(in_ready), 128'd0);
            check("bp_const", data_out, hold);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_ready_next", 128'(in_ready), 128'd1);
        check("bp_valid_next", 128'(out_valid), 128'd0);
        check("bp_queue_empty", 128'(exp_q.size()), 128'd0);

        // reset on the 2nd SUB cycle aborts the operation
        in_valid = 1'b1;
        data_in  = C1_DATA;
        key_in   = C1_KEY;
        tick();
        in_valid = 1'b0;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_valid", 128'(out_valid), 128'd0);
        check("abort_data", data_out, 128'd0);
        check("abort_ready", 128'(in_ready), 128'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("abort_ready_after", 128'(in_ready), 128'd1);
        tick();
        send('0, '0);
        drain();

        // round trip through the encryption last round
        for (int n = 0; n < 1000; n++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            y = fwd_round(x, k);
            check("model_roundtrip", model_round(y, k), x);
            send(y, k);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
